// File: rtl/qv_pkg.sv
// ---------------------------------------------------------------------------
// qv_pkg
// Shared definitions for the quaternary transfer/weight pipeline.
//   DIGIT_W      width of one quaternary digit
//   qv_digit_t   one quaternary digit, value 0..3
//   MODE_*       value of the per-transaction mode bit
//   FILL_*       digit placed in t[1:0]; subtract injects the +1 of the
//                complement of b there
// ---------------------------------------------------------------------------
package qv_pkg;

  localparam int DIGIT_W = 2;

  typedef logic [DIGIT_W-1:0] qv_digit_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  localparam qv_digit_t FILL_ADD = 2'b00;
  localparam qv_digit_t FILL_SUB = 2'b01;

endpackage

// File: rtl/qv_tw_transform_pipe_if.sv
// ---------------------------------------------------------------------------
// qv_tw_transform_pipe_if
// Operand and result handshake bundle of the transfer/weight pipeline.
//   in_valid/in_ready    operand handshake
//   in_sub, a, b         mode bit and operands (2 bits per digit)
//   out_valid/out_ready  result handshake
//   t, w, out_sub        transfer vector, weight vector, mode bit
// master = producer/consumer side, slave = the pipeline itself.
// P must match the P of the pipeline the interface is attached to.
// ---------------------------------------------------------------------------
interface qv_tw_transform_pipe_if #(parameter int P = 33);

  logic             in_valid;
  logic             in_ready;
  logic             in_sub;
  logic [2*P-1:0]   a;
  logic [2*P-1:0]   b;
  logic             out_valid;
  logic             out_ready;
  logic [2*P+1:0]   t;
  logic [2*P-1:0]   w;
  logic             out_sub;

  modport master (
    output in_valid, in_sub, a, b, out_ready,
    input  in_ready, out_valid, t, w, out_sub
  );

  modport slave (
    input  in_valid, in_sub, a, b, out_ready,
    output in_ready, out_valid, t, w, out_sub
  );

endinterface

// File: rtl/qv_tw_cell.sv
// ---------------------------------------------------------------------------
// qv_tw_cell
// Combinational per-digit transfer/weight cell.
//   a_i, b_i  operand digits (0..3)
//   sub       mode bit; when set b_i is replaced by its digit complement 3-b_i
//   t_next    transfer digit into the next position (00 or 01)
//   w_i       weight digit, (a_i + b'_i) mod 4
// ---------------------------------------------------------------------------
module qv_tw_cell
  import qv_pkg::*;
(
  input  qv_digit_t a_i,
  input  qv_digit_t b_i,
  input  logic      sub,
  output qv_digit_t t_next,
  output qv_digit_t w_i
);

  qv_digit_t  b_eff;
  logic [2:0] sum;

  // The sum of two digits is 0..6, so bit 2 alone is the ">= 4" carry.
  assign b_eff  = (sub == MODE_SUB) ? (2'd3 - b_i) : b_i;
  assign sum    = {1'b0, a_i} + {1'b0, b_eff};
  assign w_i    = sum[1:0];
  assign t_next = {1'b0, sum[2]};

endmodule

// File: rtl/qv_tw_transform_pipe.sv
// ---------------------------------------------------------------------------
// qv_tw_transform_pipe
// Pipelined quaternary transfer/weight stage with valid/ready handshake.
// Stage 1 computes T/W from the operands and registers them; stages
// 2..STAGES are plain delay registers, each with its own valid bit, so
// bubbles collapse and a full pipe can pop and push in the same cycle.
//   clk   rising-edge clock
//   rst   asynchronous active-high reset, clears valid and data registers
//   bus   qv_tw_transform_pipe_if.slave (operands in, results out)
// Parameters: P digits per operand, STAGES register stages (1..4).
// ---------------------------------------------------------------------------
module qv_tw_transform_pipe
  import qv_pkg::*;
#(
  parameter int P      = 33,
  parameter int STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  qv_tw_transform_pipe_if.slave bus
);

  localparam int TW = 2*P + 2;
  localparam int WW = 2*P;

  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("qv_tw_transform_pipe: STAGES must be in 1..4");
  end

  logic [TW-1:0] t_comb;
  logic [WW-1:0] w_comb;

  // Position 0 of T has no digit below it; it carries the +1 that turns
  // the digit complement of b into a true negation when subtracting.
  assign t_comb[1:0] = (bus.in_sub == MODE_ADD) ? FILL_ADD : FILL_SUB;

  for (genvar i = 0; i < P; i++) begin : g_cell
    qv_tw_cell u_cell (
      .a_i    (bus.a[2*i +: 2]),
      .b_i    (bus.b[2*i +: 2]),
      .sub    (bus.in_sub),
      .t_next (t_comb[2*i+2 +: 2]),
      .w_i    (w_comb[2*i +: 2])
    );
  end

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] pred;
  logic [STAGES-1:0] ld;
  logic [STAGES-1:0] adv;
  logic [TW-1:0]     t_s   [STAGES];
  logic [WW-1:0]     w_s   [STAGES];
  logic              sub_s [STAGES];

  // Load/advance chain, resolved from the output back to the input so that
  // out_ready ripples combinationally all the way to in_ready.
  always_comb begin
    logic nxt;
    pred    = '0;
    ld      = '0;
    adv     = '0;
    pred[0] = bus.in_valid;
    for (int k = 1; k < STAGES; k++) begin
      pred[k] = vld[k-1];
    end
    nxt = bus.out_ready;
    for (int k = STAGES-1; k >= 0; k--) begin
      adv[k] = vld[k] & nxt;
      ld[k]  = pred[k] & (~vld[k] | adv[k]);
      nxt    = ld[k];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic          v_q;
    logic [TW-1:0] t_q;
    logic [WW-1:0] w_q;
    logic          sub_q;
    logic [TW-1:0] t_src;
    logic [WW-1:0] w_src;
    logic          sub_src;

    if (k == 0) begin : g_first
      assign t_src   = t_comb;
      assign w_src   = w_comb;
      assign sub_src = bus.in_sub;
    end else begin : g_next
      assign t_src   = t_s[k-1];
      assign w_src   = w_s[k-1];
      assign sub_src = sub_s[k-1];
    end

    // A stage becomes valid on load and empty when it advances without a
    // refill; data only moves on load, so a drained stage keeps stale data.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q   <= 1'b0;
        t_q   <= '0;
        w_q   <= '0;
        sub_q <= 1'b0;
      end else begin
        if (ld[k]) begin
          v_q   <= 1'b1;
          t_q   <= t_src;
          w_q   <= w_src;
          sub_q <= sub_src;
        end else if (adv[k]) begin
          v_q   <= 1'b0;
        end
      end
    end

    assign vld[k]   = v_q;
    assign t_s[k]   = t_q;
    assign w_s[k]   = w_q;
    assign sub_s[k] = sub_q;
  end

  assign bus.in_ready  = ~vld[0] | adv[0];
  assign bus.out_valid = vld[STAGES-1];
  assign bus.t         = t_s[STAGES-1];
  assign bus.w         = w_s[STAGES-1];
  assign bus.out_sub   = sub_s[STAGES-1];

endmodule

// File: tb/tb_qv_tw_transform_pipe.sv
// ---------------------------------------------------------------------------
// tb_qv_tw_transform_pipe
// Scoreboard bench for qv_tw_transform_pipe with P=4, STAGES=3. Directed
// vectors carry hand-computed T/W; the driver pushes the expected result
// on each accept and a negedge monitor pops and compares on each output
// transfer.
// ---------------------------------------------------------------------------
module tb_qv_tw_transform_pipe;

  localparam int P      = 4;
  localparam int STAGES = 3;

  typedef struct {
    logic [9:0] t;
    logic [7:0] w;
    logic       sub;
    int         issue;
    bit         chk_lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  qv_tw_transform_pipe_if #(.P(P)) bus ();

  qv_tw_transform_pipe #(.P(P), .STAGES(STAGES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  exp_t mon_e;
  exp_t drv_e;
  int   pop_cyc[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  logic [7:0] va [10];
  logic [7:0] vb [10];
  logic       vs [10];
  logic [9:0] vt [10];
  logic [7:0] vw [10];

  // Free-running cycle count used for latency and back-to-back timing.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every output transfer must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("[TB] FAIL stale_output: got t=%h w=%h sub=%b, expected no output",
                 bus.t, bus.w, bus.out_sub);
      end else begin
        mon_e = sb.pop_front();
        if (bus.t !== mon_e.t || bus.w !== mon_e.w || bus.out_sub !== mon_e.sub) begin
          bad++;
          $display("[TB] FAIL result: got t=%h w=%h sub=%b, expected t=%h w=%h sub=%b",
                   bus.t, bus.w, bus.out_sub, mon_e.t, mon_e.w, mon_e.sub);
        end
        if (mon_e.chk_lat) begin
          total++;
          if (cyc - mon_e.issue != STAGES) begin
            bad++;
            $display("[TB] FAIL latency: got %0d cycles, expected %0d",
                     cyc - mon_e.issue, STAGES);
          end
        end
      end
      pop_cyc.push_back(cyc);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic driveVec(input int idx);
    bus.a      = va[idx];
    bus.b      = vb[idx];
    bus.in_sub = vs[idx];
  endtask

  task automatic pushExp(input int idx, input bit chk_lat);
    drv_e.t       = vt[idx];
    drv_e.w       = vw[idx];
    drv_e.sub     = vs[idx];
    drv_e.issue   = cyc;
    drv_e.chk_lat = chk_lat;
    sb.push_back(drv_e);
  endtask

  // Offer one vector until accepted (bounded); leaves in_valid high so
  // consecutive calls issue one transaction per cycle.
  task automatic applyStimulus(input int idx, input bit chk_lat);
    bit got;
    got = 1'b0;
    bus.in_valid = 1'b1;
    driveVec(idx);
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        got = 1'b1;
        pushExp(idx, chk_lat);
      end
      @(posedge clk);
      #1;
    end
    total++;
    if (!got) begin
      bad++;
      $display("[TB] FAIL accept_timeout: got no accept, expected accept of vector %0d", idx);
    end
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer n vectors for ncyc cycles regardless of acceptance.
  task automatic offerStalled(input int first, input int n, input int ncyc,
                              output int acc);
    int idx;
    idx = first;
    acc = 0;
    bus.in_valid = 1'b1;
    driveVec(idx);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) begin
        pushExp(idx, 1'b0);
        acc++;
        idx++;
      end
      @(posedge clk);
      #1;
      if (idx < first + n) driveVec(idx);
      else bus.in_valid = 1'b0;
    end
  endtask

  initial begin
    int acc;
    int pc0;

    // a, b, sub -> hand-computed t, w (digit 0 in the low bits)
    va[0] = 8'h00; vb[0] = 8'h00; vs[0] = 1'b0; vt[0] = 10'h000; vw[0] = 8'h00;
    va[1] = 8'hFF; vb[1] = 8'hFF; vs[1] = 1'b0; vt[1] = 10'h154; vw[1] = 8'hAA;
    va[2] = 8'h00; vb[2] = 8'h00; vs[2] = 1'b1; vt[2] = 10'h001; vw[2] = 8'hFF;
    va[3] = 8'hFF; vb[3] = 8'h00; vs[3] = 1'b1; vt[3] = 10'h155; vw[3] = 8'hAA;
    va[4] = 8'h12; vb[4] = 8'h21; vs[4] = 1'b0; vt[4] = 10'h000; vw[4] = 8'h33;
    va[5] = 8'hE4; vb[5] = 8'h1B; vs[5] = 1'b0; vt[5] = 10'h000; vw[5] = 8'hFF;
    va[6] = 8'h39; vb[6] = 8'hC6; vs[6] = 1'b1; vt[6] = 10'h051; vw[6] = 8'h22;
    va[7] = 8'hC3; vb[7] = 8'h81; vs[7] = 1'b0; vt[7] = 10'h104; vw[7] = 8'h40;
    va[8] = 8'hFF; vb[8] = 8'h55; vs[8] = 1'b0; vt[8] = 10'h154; vw[8] = 8'h00;
    va[9] = 8'h1B; vb[9] = 8'h1B; vs[9] = 1'b1; vt[9] = 10'h001; vw[9] = 8'hFF;

    bus.in_valid  = 1'b0;
    bus.in_sub    = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("reset_t", {22'd0, bus.t}, 32'd0);
    checkOutput("reset_w", {24'd0, bus.w}, 32'd0);
    checkOutput("reset_out_sub", {31'd0, bus.out_sub}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_reset", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Single add and subtract vectors with latency check
    $display("[TB] directed add/sub");
    applyStimulus(8, 1'b1);
    applyStimulus(9, 1'b1);
    idle(6);

    // Back-to-back stream
    $display("[TB] back-to-back stream");
    pc0 = pop_cyc.size();
    for (int i = 0; i < 8; i++) applyStimulus(i, 1'b1);
    idle(8);
    checkOutput("b2b_count", pop_cyc.size() - pc0, 32'd8);
    if (pop_cyc.size() - pc0 == 8)
      checkOutput("b2b_consecutive", pop_cyc[pc0+7] - pop_cyc[pc0], 32'd7);

    // Backpressure: empty pipe, output stalled, five offered
    $display("[TB] backpressure");
    bus.out_ready = 1'b0;
    offerStalled(3, 5, 8, acc);
    checkOutput("bp_accepted", acc, STAGES);
    @(negedge clk);
    checkOutput("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
    checkOutput("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
    checkOutput("bp_hold_t", {22'd0, bus.t}, {22'd0, vt[3]});
    repeat (3) @(negedge clk);
    checkOutput("bp_hold_w", {24'd0, bus.w}, {24'd0, vw[3]});
    checkOutput("bp_hold_t_late", {22'd0, bus.t}, {22'd0, vt[3]});
    @(posedge clk);
    #1;
    // Pop and push in the same cycle while full
    bus.out_ready = 1'b1;
    offerStalled(6, 2, 6, acc);
    checkOutput("bp_refill_accepted", acc, 32'd2);
    idle(6);

    // Reset with two transactions in flight
    $display("[TB] reset mid-flight");
    applyStimulus(1, 1'b0);
    applyStimulus(2, 1'b0);
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("midrst_t", {22'd0, bus.t}, 32'd0);
    checkOutput("midrst_w", {24'd0, bus.w}, 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(6);
    applyStimulus(6, 1'b1);
    idle(6);

    // Bubble collapse: one stuck in the last stage, gaps upstream
    $display("[TB] bubble collapse");
    bus.out_ready = 1'b0;
    applyStimulus(8, 1'b0);
    idle(3);
    offerStalled(4, 3, 6, acc);
    checkOutput("bubble_accepted", acc, 32'd2);
    @(negedge clk);
    checkOutput("bubble_in_ready", {31'd0, bus.in_ready}, 32'd0);
    checkOutput("bubble_head_t", {22'd0, bus.t}, {22'd0, vt[8]});
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    idle(8);

    checkOutput("scoreboard_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
